pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Hazard and sequencing controller for the five-stage pipeline. It sits beside the IF/ID and ID/EX buffers and drives their write-enable, flush and bubble controls, plus the PC write enable. It detects load-use hazards and inserts one bubble, squashes wrong-path instructions after a taken branch or jump, and freezes the whole front end while data memory is busy. Per-cycle control is a Mealy function of a small registered state machine.

## Interface
- `REG_ADDR_W`, default 6: register address width; matches the `rd` field in ID/EX.
- `FLUSH_CYCLES`, default 2, legal range 1..7: number of squash cycles after a taken branch.
- `CNT_W`, default 32: width of the performance counters.

- `clock` input 1: pipeline clock. State updates on posedge; buffers sample the controls on the following negedge.
- `reset` input 1: synchronous, active-high.
- `id_rs` input REG_ADDR_W: source register 1 of the instruction in ID.
- `id_rt` input REG_ADDR_W: source register 2 of the instruction in ID.
- `id_uses_rs` input 1: the ID instruction reads `id_rs`.
- `id_uses_rt` input 1: the ID instruction reads `id_rt`.
- `ex_rd` input REG_ADDR_W: destination register of the instruction in EX.
- `ex_memr` input 1: the EX instruction is a load.
- `branch_taken` input 1: brz/brn/j resolved taken in EX this cycle.
- `mem_busy` input 1: data memory has not completed; the pipeline must hold.
- `pc_write` output 1: PC register update enable.
- `ifid_write` output 1: IF/ID buffer load enable.
- `ifid_flush` output 1: IF/ID loads a NOP.
- `idex_write` output 1: ID/EX buffer load enable.
- `idex_bubble` output 1: ID/EX loads all control bits zero (regw, memw, memr, brz, brn, j, wai = 0).
- `stall_cycles` output CNT_W: count of cycles in which `pc_write` = 0 outside reset.
- `flush_events` output CNT_W: count of accepted taken branches.

## Operation
- Load-use hazard (`luh`) = `ex_memr` & (`ex_rd` != 0) & ((`id_uses_rs` & `id_rs` == `ex_rd`) | (`id_uses_rt` & `id_rt` == `ex_rd`)).
- States: RUN, STALL, FLUSH. A 3-bit counter `fcnt` tracks squash cycles.
- Priority, highest first: reset > `mem_busy` > `branch_taken` > `luh` > normal.
- Reset asserted:
  - `pc_write`, `ifid_write`, `idex_write` = 0.
  - `ifid_flush`, `idex_bubble` = 1.
  - State goes to RUN, `fcnt` = 0.
- `mem_busy` (any state):
  - `pc_write`, `ifid_write`, `idex_write` = 0.
  - `ifid_flush`, `idex_bubble` = 0.
  - State and `fcnt` hold.
- RUN:
  - On `branch_taken`: `pc_write` = 1, `ifid_flush` = 1, `idex_bubble` = 1, writes = 1. If FLUSH_CYCLES > 1, go to FLUSH with `fcnt` = FLUSH_CYCLES−1; otherwise stay in RUN.
  - Else on `luh`: `pc_write` = 0, `ifid_write` = 0, `idex_write` = 1, `idex_bubble` = 1. Go to STALL.
  - Else: all writes = 1, flush/bubble = 0.
- STALL: behaves as RUN except `luh` is ignored (the load has moved to MEM and forwarding covers it). Next state is RUN, or FLUSH on a taken branch.
- FLUSH:
  - `pc_write` = 1, writes = 1, `ifid_flush` = 1, `idex_bubble` = 1.
  - `branch_taken` is ignored (it comes from a squashed slot).
  - `fcnt` decrements each cycle; when `fcnt` == 1, go to RUN.
- Bubbles never clear `out_rd` or data fields; only control bits are zeroed.

## Timing
- All outputs are combinational from the registered state and the current inputs, valid before the negedge of the same cycle.
- Load-use costs exactly 1 bubble. A taken branch costs exactly FLUSH_CYCLES squashed slots.
- `mem_busy` extends any state by exactly the number of busy cycles; no control edge is lost.
- Reset deasserted at posedge N: RUN outputs apply in cycle N.
- Counters:
  - Saturate at all-ones.
  - Clear on reset.
  - `stall_cycles` increments on `luh` stalls and on `mem_busy` cycles.
  - `flush_events` increments once per accepted `branch_taken`.

## Configuration
- `HAZARD_PERF_EN` defined: both counters are implemented as specified above.
- `HAZARD_PERF_EN` not defined: the `stall_cycles` and `flush_events` ports remain but are tied to 0, and no counter flops are generated.

## Structure
- Shared package `pipeline_pkg` holds:
  - The state encodings: RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2.
  - REG_ADDR_W, and the bubble control-zero constant.
- One sub-module, `hazard_perf_counters` (two saturating counters), instantiated only under `HAZARD_PERF_EN`.

## Test plan
- Reset held 3 cycles with `branch_taken` = 1 → `ifid_flush` = `idex_bubble` = 1 and all writes 0 throughout. The cycle after release shows RUN outputs, and counters read 0.
- `ex_memr` = 1, `ex_rd` = 5, `id_rs` = 5, `id_uses_rs` = 1 → one cycle with `pc_write` = 0 and `idex_bubble` = 1, then normal. `stall_cycles` = 1. The same stimulus with `ex_rd` = 0 → no stall.
- `branch_taken` pulse with FLUSH_CYCLES = 2 → `ifid_flush` = 1 for 2 cycles, `flush_events` = 1. A second `branch_taken` during FLUSH is ignored.
- `luh` and `branch_taken` in the same cycle → branch wins: `pc_write` = 1, flush, no STALL entry.
- `mem_busy` high for 4 cycles mid-FLUSH (`fcnt` = 1) → all writes 0 for 4 cycles, then 1 flush cycle completes. `stall_cycles` += 4.
- Build without `HAZARD_PERF_EN`, repeat scenario 2 → identical control outputs, counters read 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types for the five-stage pipeline: hazard FSM states, register address width,
// and the all-zero control word a bubble loads into ID/EX.
package pipeline_pkg;

  localparam int REG_ADDR_W = 6;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic regw;
    logic memw;
    logic memr;
    logic brz;
    logic brn;
    logic j;
    logic wai;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_perf_counters.sv
// Two saturating event counters (stall cycles, accepted branch flushes); 1-cycle update latency.
// No backpressure: each counter pins at all-ones instead of wrapping.
module hazard_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_inc_i,
  input  logic             flush_inc_i,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_inc_i && (stall_q != '1)) stall_d = stall_q + 1'b1;
    if (flush_inc_i && (flush_q != '1)) flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: Mealy outputs from RUN/STALL/FLUSH state, zero latency; mem_busy freezes everything.
// Counters exist only when HAZARD_PERF_EN is defined, otherwise the counter ports read 0.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W   = pipeline_pkg::REG_ADDR_W,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_memr,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_write,
  output logic                  idex_bubble,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
);
  import pipeline_pkg::*;

  localparam bit       MULTI_FLUSH = (FLUSH_CYCLES > 1);
  localparam bit [2:0] FCNT_INIT   = 3'(FLUSH_CYCLES - 1);

  hz_state_e state_q, state_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic       luh;

  assign luh = ex_memr && (ex_rd != '0) &&
               ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = ST_RUN;
      fcnt_d      = '0;
    end else if (mem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN, ST_STALL: begin
          if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (MULTI_FLUSH) begin
              state_d = ST_FLUSH;
              fcnt_d  = FCNT_INIT;
            end else begin
              state_d = ST_RUN;
            end
          // A stall is only ever one bubble; the load is in MEM by the STALL cycle.
          end else if (luh && (state_q == ST_RUN)) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            state_d     = ST_STALL;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          fcnt_d      = fcnt_q - 3'd1;
          if (fcnt_q <= 3'd1) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = !reset && !pc_write;
  assign flush_inc = !reset && !mem_busy && branch_taken && (state_q != ST_FLUSH);

  hazard_perf_counters #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk_i      (clock),
    .rst_i      (reset),
    .stall_inc_i(stall_inc),
    .flush_inc_i(flush_inc),
    .stall_cnt_o(stall_cycles),
    .flush_cnt_o(flush_events)
  );
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic against a slot-counting model.
module tb_pipeline_hazard_ctrl;

  localparam int FC = 2;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rs, id_uses_rt, ex_memr, branch_taken, mem_busy;
  logic        pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
  logic [31:0] stall_cycles, flush_events;
  logic [4:0]  act_ctl;

  always #5 clock = ~clock;

  pipeline_hazard_ctrl #(
    .REG_ADDR_W(6),
    .FLUSH_CYCLES(FC),
    .CNT_W(32)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_rd       (ex_rd),
    .ex_memr     (ex_memr),
    .branch_taken(branch_taken),
    .mem_busy    (mem_busy),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .ifid_flush  (ifid_flush),
    .idex_write  (idex_write),
    .idex_bubble (idex_bubble),
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
  );

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble}
  assign act_ctl = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble};

  localparam logic [4:0] C_RESET  = 5'b00101;
  localparam logic [4:0] C_BUSY   = 5'b00000;
  localparam logic [4:0] C_SQUASH = 5'b11111;
  localparam logic [4:0] C_LUH    = 5'b00011;
  localparam logic [4:0] C_NORMAL = 5'b11010;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: squash slots left, whether the last issued slot was a load-use bubble.
  int          m_flush_left = 0;
  bit          m_stalled    = 0;
  longint      m_stalls     = 0;
  longint      m_flushes    = 0;
  logic [4:0]  exp_ctl;
  logic [31:0] exp_stall, exp_flush;

  task automatic drive(input bit r, input bit br, input bit busy, input bit memr,
                       input logic [5:0] rd, input logic [5:0] rs, input logic [5:0] rt,
                       input bit urs, input bit urt);
    bit hz;
    @(posedge clock);
    #1;
    reset = r; branch_taken = br; mem_busy = busy; ex_memr = memr;
    ex_rd = rd; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    hz = memr && (rd != 0) && ((urs && rs == rd) || (urt && rt == rd));
    exp_stall = PERF ? 32'(m_stalls) : 32'd0;
    exp_flush = PERF ? 32'(m_flushes) : 32'd0;
    if (r) begin
      exp_ctl = C_RESET; m_flush_left = 0; m_stalled = 0; m_stalls = 0; m_flushes = 0;
    end else if (busy) begin
      exp_ctl = C_BUSY; m_stalls++;
    end else if (m_flush_left > 0) begin
      exp_ctl = C_SQUASH; m_flush_left--; m_stalled = 0;
    end else if (br) begin
      exp_ctl = C_SQUASH; m_flush_left = FC - 1; m_flushes++; m_stalled = 0;
    end else if (hz && !m_stalled) begin
      exp_ctl = C_LUH; m_stalled = 1; m_stalls++;
    end else begin
      exp_ctl = C_NORMAL; m_stalled = 0;
    end
    #2;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 6'd0, 6'd0, 6'd0, 0, 0);
  endtask

  task automatic luh_cycle(input bit br);
    drive(0, br, 0, 1, 6'd5, 6'd5, 6'd9, 1, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 6'd0, 6'd0, 6'd0, 0, 0);
      n_tests++;
      if (act_ctl !== C_RESET) begin
        n_fail++; $display("FAIL reset_ctl[%0d]: got %b want %b", i, act_ctl, C_RESET);
      end
    end
    idle();
    n_tests++;
    if (act_ctl !== C_NORMAL) begin
      n_fail++; $display("FAIL reset_release: got %b want %b", act_ctl, C_NORMAL);
    end
    n_tests++;
    if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
      n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cycles, flush_events);
    end
  endtask

  task automatic test_load_use();
    drive(1, 0, 0, 0, 6'd0, 6'd0, 6'd0, 0, 0);
    luh_cycle(0);
    n_tests++;
    if (act_ctl !== C_LUH) begin
      n_fail++; $display("FAIL luh_bubble: got %b want %b", act_ctl, C_LUH);
    end
    luh_cycle(0);
    n_tests++;
    if (act_ctl !== C_NORMAL) begin
      n_fail++; $display("FAIL luh_once: got %b want %b", act_ctl, C_NORMAL);
    end
    idle();
    n_tests++;
    if (stall_cycles !== (PERF ? 32'd1 : 32'd0)) begin
      n_fail++; $display("FAIL luh_count: got %0d want %0d", stall_cycles, PERF ? 1 : 0);
    end
    drive(0, 0, 0, 1, 6'd0, 6'd0, 6'd9, 1, 0);
    n_tests++;
    if (act_ctl !== C_NORMAL) begin
      n_fail++; $display("FAIL luh_rd0: got %b want %b", act_ctl, C_NORMAL);
    end
    drive(0, 0, 0, 1, 6'd7, 6'd1, 6'd7, 1, 1);
    n_tests++;
    if (act_ctl !== C_LUH) begin
      n_fail++; $display("FAIL luh_rt: got %b want %b", act_ctl, C_LUH);
    end
  endtask

  task automatic test_branch();
    drive(1, 0, 0, 0, 6'd0, 6'd0, 6'd0, 0, 0);
    drive(0, 1, 0, 0, 6'd0, 6'd0, 6'd0, 0, 0);
    n_tests++;
    if (act_ctl !== C_SQUASH) begin
      n_fail++; $display("FAIL br_slot0: got %b want %b", act_ctl, C_SQUASH);
    end
    drive(0, 1, 0, 0, 6'd0, 6'd0, 6'd0, 0, 0);
    n_tests++;
    if (act_ctl !== C_SQUASH) begin
      n_fail++; $display("FAIL br_slot1: got %b want %b", act_ctl, C_SQUASH);
    end
    idle();
    n_tests++;
    if (act_ctl !== C_NORMAL) begin
      n_fail++; $display("FAIL br_done: got %b want %b", act_ctl, C_NORMAL);
    end
    n_tests++;
    if (flush_events !== (PERF ? 32'd1 : 32'd0)) begin
      n_fail++; $display("FAIL br_count: got %0d want %0d", flush_events, PERF ? 1 : 0);
    end
  endtask

  task automatic test_luh_vs_branch();
    drive(1, 0, 0, 0, 6'd0, 6'd0, 6'd0, 0, 0);
    luh_cycle(1);
    n_tests++;
    if (act_ctl !== C_SQUASH) begin
      n_fail++; $display("FAIL luhbr_win: got %b want %b", act_ctl, C_SQUASH);
    end
    luh_cycle(0);
    idle();
    n_tests++;
    if (act_ctl !== C_NORMAL || stall_cycles !== 32'd0) begin
      n_fail++; $display("FAIL luhbr_nostall: got %b/%0d want %b/0", act_ctl, stall_cycles, C_NORMAL);
    end
  endtask

  task automatic test_busy_mid_flush();
    drive(1, 0, 0, 0, 6'd0, 6'd0, 6'd0, 0, 0);
    drive(0, 1, 0, 0, 6'd0, 6'd0, 6'd0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0, 6'd0, 6'd0, 6'd0, 0, 0);
      n_tests++;
      if (act_ctl !== C_BUSY) begin
        n_fail++; $display("FAIL busy_hold[%0d]: got %b want %b", i, act_ctl, C_BUSY);
      end
    end
    idle();
    n_tests++;
    if (act_ctl !== C_SQUASH) begin
      n_fail++; $display("FAIL busy_resume: got %b want %b", act_ctl, C_SQUASH);
    end
    idle();
    n_tests++;
    if (act_ctl !== C_NORMAL || stall_cycles !== (PERF ? 32'd4 : 32'd0)) begin
      n_fail++; $display("FAIL busy_after: got %b/%0d want %b/%0d", act_ctl, stall_cycles, C_NORMAL, PERF ? 4 : 0);
    end
  endtask

  task automatic test_random();
    drive(1, 0, 0, 0, 6'd0, 6'd0, 6'd0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 4) == 0,
            1'($urandom), 6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
            6'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
      n_tests++;
      if (act_ctl !== exp_ctl || stall_cycles !== exp_stall || flush_events !== exp_flush) begin
        n_fail++;
        $display("FAIL random[%0d]: ctl=%b st=%0d fl=%0d want ctl=%b st=%0d fl=%0d",
                 i, act_ctl, stall_cycles, flush_events, exp_ctl, exp_stall, exp_flush);
      end
    end
  endtask

  initial begin
    reset = 1'b1; branch_taken = 1'b0; mem_busy = 1'b0; ex_memr = 1'b0;
    ex_rd = '0; id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    test_reset();
    test_load_use();
    test_branch();
    test_luh_vs_branch();
    test_busy_mid_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
